// File: rtl/pulse_handshake_tx_pkg.sv
// Shared types and constants for the pulse_handshake_tx event transmitter
// and the synchronizer it uses.
package pulse_handshake_tx_pkg;

  localparam int SYNC_MIN = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } hs_state_e;

endpackage

// File: rtl/bit_sync.sv
// N-flop single-bit synchronizer with synchronous reset to 0; the stage count
// is clamped to the metastability minimum.
module bit_sync
  import pulse_handshake_tx_pkg::*;
#(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  localparam int N = (STAGES < SYNC_MIN) ? SYNC_MIN : STAGES;

  logic [N-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/pulse_handshake_tx.sv
// Source side of a 4-phase req/ack crossing: counts rising edges of pulse_in
// and retires each one with a full req/ack handshake, with sticky error flags.
module pulse_handshake_tx
  import pulse_handshake_tx_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TMO_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse_in,
  input  logic             ack_in,
  input  logic             clr_err,
  output logic             req_out,
  output logic [CNT_W-1:0] pending,
  output logic             busy,
  output logic             overflow,
  output logic             timeout
);

  localparam int SYNC_N = (SYNC_STAGES < SYNC_MIN) ? SYNC_MIN : SYNC_STAGES;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [TMO_W-1:0] TMO_MAX = '1;

  hs_state_e         state_q, state_d;
  logic [CNT_W-1:0]  pending_q, pending_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d, tmo_inc;
  logic [SYNC_N-1:0] flush_q;
  logic              pulse_in_d_q;
  logic              req_q, busy_q, ovf_q, tmo_flag_q;
  logic              ack_s, sync_ready, ev, dec, ovf_set, tmo_set;

  bit_sync #(.STAGES(SYNC_N)) u_ack_sync (
    .clk (clk),
    .rst (rst),
    .d_i (ack_in),
    .q_o (ack_s)
  );

  // The synchronizer reads 0 right after reset regardless of the far side, so
  // its output is not trusted until a full flush has passed.
  assign sync_ready = flush_q[SYNC_N-1];
  assign ev         = pulse_in & ~pulse_in_d_q;
  assign tmo_inc    = tmo_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    tmo_d     = tmo_q;
    dec       = 1'b0;
    ovf_set   = 1'b0;
    tmo_set   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pending_q != '0 && sync_ready && !ack_s) begin
          state_d = ST_REQ;
          tmo_d   = '0;
        end
      end
      ST_REQ: begin
        if (ack_s) begin
          state_d = ST_RELEASE;
          dec     = (pending_q != '0);
        end else if (tmo_inc == TMO_MAX) begin
          state_d = ST_RELEASE;
          tmo_set = 1'b1;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      ST_RELEASE: begin
        if (!ack_s) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (ev && !dec) begin
      if (pending_q == CNT_MAX) begin
        ovf_set = 1'b1;
      end else begin
        pending_d = pending_q + 1'b1;
      end
    end else if (!ev && dec) begin
      pending_d = pending_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pulse_in_d_q <= 1'b1;
      state_q      <= ST_IDLE;
      pending_q    <= '0;
      tmo_q        <= '0;
      flush_q      <= '0;
      req_q        <= 1'b0;
      busy_q       <= 1'b0;
      ovf_q        <= 1'b0;
      tmo_flag_q   <= 1'b0;
    end else begin
      pulse_in_d_q <= pulse_in;
      state_q      <= state_d;
      pending_q    <= pending_d;
      tmo_q        <= tmo_d;
      flush_q      <= {flush_q[SYNC_N-2:0], 1'b1};
      req_q        <= (state_d == ST_REQ);
      busy_q       <= (state_d != ST_IDLE);
      // Setting takes priority over a simultaneous clear.
      ovf_q        <= ovf_set | (ovf_q & ~clr_err);
      tmo_flag_q   <= tmo_set | (tmo_flag_q & ~clr_err);
    end
  end

  assign req_out  = req_q;
  assign pending  = pending_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;
  assign timeout  = tmo_flag_q;

endmodule
